// File: rtl/rom_port_arbiter_16.sv
// Round-robin arbiter sharing one ROM address port among 16 requesters.
// A tenure lasts at most MAX_HOLD granted cycles and owners are always
// separated by at least two zero-select cycles. Returning ROM data is tagged
// with its owner's index after a fixed LATENCY-cycle pipeline.
//
// Ports:
//   clock       - system clock, rising edge
//   reset       - synchronous active-high reset
//   req         - per-requester request, held until the requester is done
//   grant       - one-hot (or zero) select for the address mux
//   grant_id    - binary index of the current owner, 0 when idle
//   busy        - grant is non-zero
//   rdata_valid - ROM data bus holds valid data this cycle
//   rdata_id    - owner index of that data, 0 when not valid
module rom_port_arbiter_16 #(
    parameter int unsigned LATENCY  = 2,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] req,
    output logic [15:0] grant,
    output logic [3:0]  grant_id,
    output logic        busy,
    output logic        rdata_valid,
    output logic [3:0]  rdata_id
);

    localparam int unsigned HOLD_W  = 4;
    localparam int unsigned STAGE_W = 5;
    localparam int unsigned PIPE_W  = LATENCY * STAGE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [15:0]         grant_q, grant_d;
    logic [3:0]          grant_id_q, grant_id_d;
    logic                busy_q, busy_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [3:0]          ptr_q, ptr_d;
    logic [PIPE_W-1:0]   pipe_q, pipe_d;

    logic                found_c;
    logic [3:0]          winner_c;
    logic [3:0]          idx_c;
    logic                read_c;
    logic                own_exit_c;
    logic [STAGE_W-1:0]  stage0_c;

    // First requester at or above ptr, wrapping 15 -> 0.
    always_comb begin : pick
        found_c  = 1'b0;
        winner_c = 4'd0;
        idx_c    = 4'd0;
        for (int i = 0; i < 16; i++) begin
            idx_c = ptr_q + 4'(i);
            if (!found_c && req[idx_c]) begin
                found_c  = 1'b1;
                winner_c = idx_c;
            end
        end
    end

    // A read is issued whenever the port is owned and the owner still asks.
    assign read_c     = busy_q & req[grant_id_q];
    assign own_exit_c = !req[grant_id_q] || (hold_q == HOLD_W'(MAX_HOLD));

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 16'h0000;
            grant_id_q <= 4'd0;
            busy_q     <= 1'b0;
            hold_q     <= '0;
            ptr_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            hold_q     <= hold_d;
            ptr_q      <= ptr_d;
        end
    end

    // Next-state logic.
    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:    if (found_c) state_d = OWN;
            OWN:     if (own_exit_c) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, hold counter and pointer.
    always_comb begin : outputs
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        hold_d     = hold_q;
        ptr_d      = ptr_q;
        case (state_q)
            IDLE: begin
                if (found_c) begin
                    grant_d    = 16'(1) << winner_c;
                    grant_id_d = winner_c;
                    busy_d     = 1'b1;
                    hold_d     = HOLD_W'(1);
                end else begin
                    grant_d    = 16'h0000;
                    grant_id_d = 4'd0;
                    busy_d     = 1'b0;
                end
            end
            OWN: begin
                if (own_exit_c) begin
                    grant_d    = 16'h0000;
                    grant_id_d = 4'd0;
                    busy_d     = 1'b0;
                    ptr_d      = grant_id_q + 4'd1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                grant_d    = 16'h0000;
                grant_id_d = 4'd0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // Return pipeline: LATENCY stages of {valid, id}, newest in the low bits.
    assign stage0_c = {read_c, read_c ? grant_id_q : 4'd0};
    assign pipe_d   = (pipe_q << STAGE_W) | PIPE_W'(stage0_c);

    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign rdata_valid = pipe_q[PIPE_W-1];
    assign rdata_id    = pipe_q[PIPE_W-2 -: 4];

endmodule

// File: tb/tb_rom_port_arbiter_16.sv
// Testbench for rom_port_arbiter_16: directed scenarios plus randomized
// request traffic, checked every cycle against a tenure-level reference model.
module tb_rom_port_arbiter_16;

    localparam int L  = 2;
    localparam int MH = 8;
    localparam int NC = 8192;

    logic        clock;
    logic        reset;
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  grant_id;
    logic        busy;
    logic        rdata_valid;
    logic [3:0]  rdata_id;

    rom_port_arbiter_16 #(.LATENCY(L), .MAX_HOLD(MH)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .busy        (busy),
        .rdata_valid (rdata_valid),
        .rdata_id    (rdata_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 0;

    // Reference model: who owns the port, how many reads this tenure,
    // whether the cycle after a tenure is still blocked, and a timeline of
    // expected returned data indexed by cycle number.
    int        m_owner, m_n, m_ptr, last_read;
    bit        m_block;
    bit        exp_v  [NC];
    logic [3:0] exp_id[NC];

    // Observation of the DUT for directed checks.
    int obs_owners[$];
    int obs_len[$];
    int cur_len, obs_reads;
    bit prev_busy;
    int rem[16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_n     = 0;
        m_ptr   = 0;
        m_block = 0;
        for (int k = cyc + 1; k < NC; k++) begin
            exp_v[k]  = 1'b0;
            exp_id[k] = 4'd0;
        end
    endfunction

    function automatic void model_step(input logic [15:0] r);
        bit found;
        last_read = -1;
        if (m_owner >= 0) begin
            if (r[4'(m_owner)]) begin
                last_read = m_owner;
                m_n++;
                if (cyc + L < NC) begin
                    exp_v[cyc + L]  = 1'b1;
                    exp_id[cyc + L] = 4'(m_owner);
                end
            end
            if (!r[4'(m_owner)] || m_n == MH) begin
                m_ptr   = (m_owner + 1) % 16;
                m_owner = -1;
                m_block = 1;
            end
        end else if (m_block) begin
            m_block = 0;
        end else begin
            found = 0;
            for (int k = 0; k < 16; k++) begin
                if (!found && r[4'(m_ptr + k)]) begin
                    found   = 1;
                    m_owner = (m_ptr + k) % 16;
                    m_n     = 0;
                end
            end
        end
    endfunction

    task automatic tick(input logic [15:0] r, input logic rs);
        logic [15:0] eg;
        @(negedge clock);
        if (chk_en) begin
            eg = (m_owner >= 0) ? (16'(1) << m_owner) : 16'h0000;
            check("grant",       32'(grant),       32'(eg));
            check("grant_id",    32'(grant_id),    (m_owner >= 0) ? 32'(m_owner) : 32'd0);
            check("busy",        32'(busy),        32'(m_owner >= 0));
            check("rdata_valid", 32'(rdata_valid), 32'(exp_v[cyc]));
            check("rdata_id",    32'(rdata_id),    32'(exp_id[cyc]));
            check("onehot0",     32'($onehot0(grant)), 32'd1);
            if (busy && !prev_busy) begin
                obs_owners.push_back(int'(grant_id));
                cur_len = 0;
            end
            if (busy) cur_len++;
            if (!busy && prev_busy) obs_len.push_back(cur_len);
            if (rdata_valid === 1'b1) obs_reads++;
            prev_busy = busy;
        end
        req   = r;
        reset = rs;
        @(posedge clock);
        if (rs) begin
            model_reset();
            last_read = -1;
        end else begin
            model_step(r);
        end
        cyc++;
    endtask

    task automatic do_reset();
        tick(16'h0000, 1'b1);
        tick(16'h0000, 1'b1);
    endtask

    task automatic clear_obs();
        obs_owners.delete();
        obs_len.delete();
        obs_reads = 0;
    endtask

    // Requesters hold req until their remaining read count is used up.
    task automatic run_agent(input int n, input bit rnd);
        logic [15:0] r;
        logic        rs;
        for (int c = 0; c < n; c++) begin
            if (rnd) begin
                for (int i = 0; i < 16; i++)
                    if (rem[i] == 0 && $urandom_range(0, 7) == 0)
                        rem[i] = $urandom_range(1, 12);
            end
            r = 16'h0000;
            for (int i = 0; i < 16; i++) r[i] = (rem[i] > 0);
            rs = rnd && ($urandom_range(0, 99) == 0);
            tick(r, rs);
            if (last_read >= 0 && rem[last_read] > 0) rem[last_read]--;
        end
    endtask

    initial begin
        req   = 16'h0000;
        reset = 1'b1;
        for (int k = 0; k < NC; k++) begin
            exp_v[k]  = 1'b0;
            exp_id[k] = 4'd0;
        end
        for (int i = 0; i < 16; i++) rem[i] = 0;
        cur_len = 0; obs_reads = 0; prev_busy = 0; last_read = -1;
        model_reset();
        tick(16'h0000, 1'b1);
        chk_en = 1;
        do_reset();

        // Single requester: three reads from index 2.
        clear_obs();
        rem[2] = 3;
        run_agent(12, 0);
        check("single_tenures", 32'(obs_owners.size()), 32'd1);
        check("single_owner", obs_owners.size() > 0 ? 32'(obs_owners[0]) : 32'hFFFF, 32'd2);
        check("single_reads", 32'(obs_reads), 32'd3);

        // Simultaneous requests 0 and 5, then 0 and 6 to expose ptr = 6.
        do_reset();
        clear_obs();
        rem[0] = 2; rem[5] = 2;
        run_agent(20, 0);
        check("simul_n", 32'(obs_owners.size()), 32'd2);
        check("simul_first",  obs_owners.size() > 0 ? 32'(obs_owners[0]) : 32'hFFFF, 32'd0);
        check("simul_second", obs_owners.size() > 1 ? 32'(obs_owners[1]) : 32'hFFFF, 32'd5);
        clear_obs();
        rem[0] = 1; rem[6] = 1;
        run_agent(16, 0);
        check("ptr6_first",  obs_owners.size() > 0 ? 32'(obs_owners[0]) : 32'hFFFF, 32'd6);
        check("ptr6_second", obs_owners.size() > 1 ? 32'(obs_owners[1]) : 32'hFFFF, 32'd0);

        // Hold limit: 3 and 9 continuously, ptr now 1.
        clear_obs();
        for (int c = 0; c < 60; c++) tick(16'h0208, 1'b0);
        for (int c = 0; c < 8; c++)  tick(16'h0000, 1'b0);
        for (int t = 0; t < 4; t++) begin
            check("hold_owner", obs_owners.size() > t ? 32'(obs_owners[t]) : 32'hFFFF,
                  (t % 2 == 0) ? 32'd3 : 32'd9);
            check("hold_len", obs_len.size() > t ? 32'(obs_len[t]) : 32'hFFFF, 32'(MH));
        end

        // Full round robin from ptr = 0.
        do_reset();
        clear_obs();
        for (int c = 0; c < 175; c++) tick(16'hFFFF, 1'b0);
        for (int c = 0; c < 6; c++)   tick(16'h0000, 1'b0);
        for (int t = 0; t < 17; t++)
            check("rr_order", obs_owners.size() > t ? 32'(obs_owners[t]) : 32'hFFFF, 32'(t % 16));

        // Reset during the second granted cycle of index 7.
        do_reset();
        tick(16'h0080, 1'b0);
        tick(16'h0080, 1'b0);
        tick(16'h0080, 1'b1);
        clear_obs();
        for (int c = 0; c < 8; c++) tick(16'h0000, 1'b0);
        check("rst_no_reads", 32'(obs_reads), 32'd0);
        check("rst_no_grant", 32'(obs_owners.size()), 32'd0);
        rem[0] = 1; rem[15] = 1;
        run_agent(14, 0);
        check("rst_first", obs_owners.size() > 0 ? 32'(obs_owners[0]) : 32'hFFFF, 32'd0);
        check("rst_second", obs_owners.size() > 1 ? 32'(obs_owners[1]) : 32'hFFFF, 32'd15);

        // Idle port.
        clear_obs();
        for (int c = 0; c < 100; c++) tick(16'h0000, 1'b0);
        check("idle_grants", 32'(obs_owners.size()), 32'd0);
        check("idle_reads",  32'(obs_reads), 32'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 16; i++) rem[i] = 0;
        run_agent(600, 1);
        for (int i = 0; i < 16; i++) rem[i] = 0;
        run_agent(10, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
